// File: rtl/noc_core_iface_pkg.sv
// Shared NoC definitions: node id width, node count, flit field offsets
// (bit 0 = MSB of the flit), flit length derivation and the TX state enum.
package noc_core_iface_pkg;

  localparam int NODE_W   = 4;
  localparam int NODE_CNT = 9;

  // Field offsets counted from the MSB of the flit.
  localparam int FLIT_VALID_OFS = 0;
  localparam int FLIT_DST_OFS   = 1;
  localparam int FLIT_SRC_OFS   = 5;
  localparam int FLIT_DATA_OFS  = 9;

  function automatic int flit_len(input int data_w);
    return FLIT_DATA_OFS + data_w;
  endfunction

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/noc_core_iface_rx_fifo.sv
// First-word-fall-through FIFO for received {src, data}; pointers carry one
// extra wrap bit so full and empty are distinguishable without a counter.
module noc_rx_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, rd_q;
  logic [W-1:0] mem [DEPTH];
  logic         do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // When full, a same-cycle pop frees the slot being written.
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/noc_core_iface.sv
// Core-side NoC endpoint: TX framing FSM, RX destination filter and RX FIFO.
// Optional statistics counters are enabled by defining NOC_IFACE_STATS_EN.
module noc_core_iface
  import noc_core_iface_pkg::*;
#(
  parameter int NODE_ID  = 0,
  parameter int DATA_W   = 32,
  parameter int RX_DEPTH = 4,
  localparam int PL      = FLIT_DATA_OFS + DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [3:0]        tx_dst,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_err,
  output logic [PL-1:0]     flit_out,
  input  logic              noc_avail,
  input  logic [PL-1:0]     flit_in,
  output logic              rx_avail,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [3:0]        rx_src,
  output logic [DATA_W-1:0] rx_data,
  output logic              tx_state_dbg
`ifdef NOC_IFACE_STATS_EN
  ,
  output logic [15:0]       tx_cnt,
  output logic [15:0]       rx_cnt,
  output logic [15:0]       drop_cnt
`endif
);

  localparam int VALID_IDX = PL - 1 - FLIT_VALID_OFS;
  localparam int DST_IDX   = PL - 1 - FLIT_DST_OFS;
  localparam int SRC_IDX   = PL - 1 - FLIT_SRC_OFS;
  localparam logic [NODE_W-1:0] MY_ID  = NODE_W'(NODE_ID);
  localparam logic [NODE_W-1:0] MAX_ID = NODE_W'(NODE_CNT - 1);

  // valid/ready: a transfer happens on a clock edge where both are high;
  // tx_valid/tx_dst/tx_data and flit_out must stay stable until then.

  // ---------------- TX path ----------------
  tx_state_e         state_q, state_d;
  logic [PL-1:0]     flit_q, flit_d;
  logic              tx_err_q;
  logic              tx_take, tx_bad, tx_good;

  always_comb begin
    state_d  = state_q;
    flit_d   = flit_q;
    tx_ready = (state_q == TX_IDLE) | noc_avail;
    tx_take  = tx_valid & tx_ready;
    tx_bad   = (tx_dst > MAX_ID);
    tx_good  = tx_take & ~tx_bad;
    case (state_q)
      TX_IDLE: begin
        if (tx_good) begin
          state_d = TX_SEND;
          flit_d  = {1'b1, tx_dst, MY_ID, tx_data};
        end
      end
      TX_SEND: begin
        if (tx_good) begin
          flit_d = {1'b1, tx_dst, MY_ID, tx_data};
        end else if (noc_avail) begin
          state_d = TX_IDLE;
          flit_d  = '0;
        end
      end
      default: begin
        state_d = TX_IDLE;
        flit_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= TX_IDLE;
      flit_q   <= '0;
      tx_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      flit_q   <= flit_d;
      tx_err_q <= tx_take & tx_bad;
    end
  end

  assign flit_out     = flit_q;
  assign tx_err       = tx_err_q;
  assign tx_state_dbg = state_q;

  // ---------------- RX path ----------------
  logic                     in_valid, in_mine, rx_push, rx_pop, rx_full, rx_empty;
  logic [NODE_W+DATA_W-1:0] rx_head;

  assign in_valid = flit_in[VALID_IDX];
  assign in_mine  = in_valid && (flit_in[DST_IDX -: NODE_W] == MY_ID);
  assign rx_pop   = rx_ready & ~rx_empty;
  assign rx_push  = in_mine & (~rx_full | rx_pop);

  noc_rx_fifo #(
    .W     (NODE_W + DATA_W),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_ready),
    .din   (flit_in[SRC_IDX:0]),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  assign rx_avail = ~rx_full;
  assign rx_valid = ~rx_empty;
  assign rx_src   = rx_head[NODE_W+DATA_W-1 -: NODE_W];
  assign rx_data  = rx_head[DATA_W-1:0];

`ifdef NOC_IFACE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_cnt   <= '0;
      rx_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      tx_cnt   <= sat_add(tx_cnt, {1'b0, (state_q == TX_SEND) & noc_avail});
      rx_cnt   <= sat_add(rx_cnt, {1'b0, rx_push});
      drop_cnt <= sat_add(drop_cnt, 2'(in_valid & ~rx_push) + 2'(tx_err_q));
    end
  end
`endif

endmodule

// File: tb/tb_noc_core_iface.sv
// Self-checking bench for noc_core_iface (NODE_ID=4): directed TX/RX cases,
// a randomized traffic phase and a reset-during-send case.
module tb_noc_core_iface;

  localparam int NODE_ID  = 4;
  localparam int DATA_W   = 32;
  localparam int RX_DEPTH = 4;
  localparam int PL       = 9 + DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              tx_valid;
  logic              tx_ready;
  logic [3:0]        tx_dst;
  logic [DATA_W-1:0] tx_data;
  logic              tx_err;
  logic [PL-1:0]     flit_out;
  logic              noc_avail;
  logic [PL-1:0]     flit_in;
  logic              rx_avail;
  logic              rx_valid;
  logic              rx_ready;
  logic [3:0]        rx_src;
  logic [DATA_W-1:0] rx_data;
  logic              tx_state_dbg;
`ifdef NOC_IFACE_STATS_EN
  logic [15:0]       tx_cnt, rx_cnt, drop_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [PL-1:0]       tx_q [$];
  logic [DATA_W+3:0]   rx_q [$];

  noc_core_iface #(
    .NODE_ID  (NODE_ID),
    .DATA_W   (DATA_W),
    .RX_DEPTH (RX_DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_dst       (tx_dst),
    .tx_data      (tx_data),
    .tx_err       (tx_err),
    .flit_out     (flit_out),
    .noc_avail    (noc_avail),
    .flit_in      (flit_in),
    .rx_avail     (rx_avail),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_src       (rx_src),
    .rx_data      (rx_data),
    .tx_state_dbg (tx_state_dbg)
`ifdef NOC_IFACE_STATS_EN
    ,
    .tx_cnt       (tx_cnt),
    .rx_cnt       (rx_cnt),
    .drop_cnt     (drop_cnt)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [PL-1:0] mk_flit(input logic [3:0] dst, input logic [3:0] src,
                                            input logic [DATA_W-1:0] data);
    return {1'b1, dst, src, data};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare every transfer against the head of its expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (flit_out[PL-1] && noc_avail) begin
        if (tx_q.size() == 0) check("tx_unexpected", 64'(flit_out), 64'd0);
        else                  check("tx_flit", 64'(flit_out), 64'(tx_q.pop_front()));
      end
      if (rx_valid && rx_ready) begin
        if (rx_q.size() == 0) check("rx_unexpected", 64'({rx_src, rx_data}), 64'd0);
        else                  check("rx_head", 64'({rx_src, rx_data}), 64'(rx_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : main
    logic [PL-1:0]     exp_flit;
    logic [3:0]        dsts [3];
    logic [3:0]        src;
    logic [DATA_W-1:0] d;
    int                rx_n;
    logic              tx_busy;
    logic              ready_m, pop_m, push_m, v;
    logic [3:0]        rdst;

    dsts = '{4'd0, 4'd4, 4'd7};
    rst = 1'b1; tx_valid = 0; tx_dst = 0; tx_data = 0; noc_avail = 0;
    flit_in = '0; rx_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cyc();

    // Reset state
    check("rst_flit_out", 64'(flit_out), 0);
    check("rst_tx_ready", 64'(tx_ready), 1);
    check("rst_rx_avail", 64'(rx_avail), 1);
    check("rst_rx_valid", 64'(rx_valid), 0);
    check("rst_rx_src",   64'(rx_src), 0);
    check("rst_rx_data",  64'(rx_data), 0);
    check("rst_tx_err",   64'(tx_err), 0);
    check("rst_state",    64'(tx_state_dbg), 0);

    // Stalled send: flit held for 4 cycles while the router is busy for 3
    tx_valid = 1; tx_dst = 4'd8; tx_data = 32'hDEADBEEF; noc_avail = 0;
    exp_flit = mk_flit(4'd8, 4'(NODE_ID), 32'hDEADBEEF);
    tx_q.push_back(exp_flit);
    #1 check("idle_ready", 64'(tx_ready), 1);
    cyc();
    tx_valid = 0;
    for (int i = 0; i < 4; i++) begin
      check("stall_hold", 64'(flit_out), 64'(exp_flit));
      if (i < 3) begin
        #1 check("stall_ready", 64'(tx_ready), 0);
      end else begin
        noc_avail = 1;
      end
      cyc();
    end
    check("after_send_idle", 64'(flit_out), 0);

    // Streaming: three flits back to back, no bubble
    for (int k = 0; k < 3; k++) begin
      tx_valid = 1; tx_dst = dsts[k]; tx_data = $urandom;
      exp_flit = mk_flit(dsts[k], 4'(NODE_ID), tx_data);
      tx_q.push_back(exp_flit);
      cyc();
      check("stream_flit", 64'(flit_out), 64'(exp_flit));
    end
    tx_valid = 0;
    cyc();
    check("stream_end", 64'(flit_out), 0);
    check("stream_drained", 64'(tx_q.size()), 0);
    noc_avail = 0;

    // RX fill with the core stalled: 4 stored, 5th dropped
    rx_ready = 0;
    for (int k = 0; k < 5; k++) begin
      src = 4'($urandom_range(0, 8)); d = $urandom;
      flit_in = mk_flit(4'(NODE_ID), src, d);
      if (k < 4) rx_q.push_back({src, d});
      cyc();
      check("fill_valid", 64'(rx_valid), 1);
      check("fill_avail", 64'(rx_avail), 64'(k < 3));
    end
    flit_in = '0;
`ifdef NOC_IFACE_STATS_EN
    check("stat_drop_full", 64'(drop_cnt), 1);
    check("stat_rx_fill", 64'(rx_cnt), 4);
`endif

    // Full FIFO with simultaneous push and pop: occupancy stays at 4
    rx_ready = 1;
    src = 4'd9; d = $urandom;
    flit_in = mk_flit(4'(NODE_ID), src, d);
    rx_q.push_back({src, d});
    cyc();
    flit_in = '0; rx_ready = 0;
    check("pushpop_avail", 64'(rx_avail), 0);
    check("pushpop_valid", 64'(rx_valid), 1);

    // Drain plus one pop while empty
    rx_ready = 1;
    repeat (5) cyc();
    rx_ready = 0;
    check("drain_valid", 64'(rx_valid), 0);
    check("drain_avail", 64'(rx_avail), 1);
    check("drain_queue", 64'(rx_q.size()), 0);

    // Misrouted and invalid flits are not stored
    flit_in = mk_flit(4'd2, 4'd1, $urandom);
    cyc();
    check("misroute_valid", 64'(rx_valid), 0);
    flit_in = {1'b0, 4'(NODE_ID), 4'd1, 32'h12345678};
    cyc();
    flit_in = '0;
    check("invalid_valid", 64'(rx_valid), 0);
`ifdef NOC_IFACE_STATS_EN
    check("stat_drop_misroute", 64'(drop_cnt), 2);
`endif

    // Bad destination: one tx_err pulse, no flit
    tx_valid = 1; tx_dst = 4'd11; tx_data = $urandom;
    cyc();
    tx_valid = 0;
    check("err_pulse", 64'(tx_err), 1);
    check("err_no_flit", 64'(flit_out), 0);
    check("err_state", 64'(tx_state_dbg), 0);
    cyc();
    check("err_once", 64'(tx_err), 0);
    check("err_no_flit2", 64'(flit_out), 0);
`ifdef NOC_IFACE_STATS_EN
    check("stat_drop_err", 64'(drop_cnt), 3);
    check("stat_tx", 64'(tx_cnt), 4);
    check("stat_rx", 64'(rx_cnt), 5);
`endif

    // Randomized traffic against a small occupancy / busy model
    rx_n = 0; tx_busy = 0;
    for (int c = 0; c < 300; c++) begin
      tx_valid  = 1'($urandom_range(0, 1));
      tx_dst    = 4'($urandom_range(0, 8));
      tx_data   = $urandom;
      noc_avail = ($urandom_range(0, 3) != 0);
      rx_ready  = 1'($urandom_range(0, 1));
      v         = ($urandom_range(0, 3) != 0);
      rdst      = $urandom_range(0, 2) != 0 ? 4'(NODE_ID) : 4'($urandom_range(0, 8));
      src       = 4'($urandom_range(0, 8));
      d         = $urandom;
      flit_in   = {v, rdst, src, d};
      #1;
      ready_m = !tx_busy || noc_avail;
      check("rnd_tx_ready", 64'(tx_ready), 64'(ready_m));
      check("rnd_rx_avail", 64'(rx_avail), 64'(rx_n < RX_DEPTH));
      check("rnd_rx_valid", 64'(rx_valid), 64'(rx_n > 0));
      if (tx_valid && ready_m) begin
        tx_q.push_back(mk_flit(tx_dst, 4'(NODE_ID), tx_data));
        tx_busy = 1;
      end else if (noc_avail) begin
        tx_busy = 0;
      end
      pop_m  = (rx_n > 0) && rx_ready;
      push_m = v && (rdst == 4'(NODE_ID)) && ((rx_n < RX_DEPTH) || pop_m);
      if (push_m) rx_q.push_back({src, d});
      rx_n = rx_n + int'(push_m) - int'(pop_m);
      cyc();
    end
    tx_valid = 0; flit_in = '0; noc_avail = 1; rx_ready = 1;
    repeat (8) cyc();
    check("rnd_tx_drained", 64'(tx_q.size()), 0);
    check("rnd_rx_drained", 64'(rx_q.size()), 0);

    // Reset in the middle of a send with RX data buffered
    noc_avail = 0; rx_ready = 0;
    tx_valid = 1; tx_dst = 4'd3; tx_data = $urandom;
    flit_in = mk_flit(4'(NODE_ID), 4'd5, $urandom);
    cyc();
    tx_valid = 0; flit_in = '0;
    check("pre_rst_flit", 64'(flit_out[PL-1]), 1);
    check("pre_rst_rx", 64'(rx_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_flit", 64'(flit_out), 0);
    check("mid_rst_rx_valid", 64'(rx_valid), 0);
    check("mid_rst_rx_avail", 64'(rx_avail), 1);
    check("mid_rst_rx_data", 64'(rx_data), 0);
    check("mid_rst_ready", 64'(tx_ready), 1);
    tx_q.delete();
    rx_q.delete();
    cyc();
    rst = 1'b0;
    cyc();
    check("post_rst_flit", 64'(flit_out), 0);
    check("post_rst_rx", 64'(rx_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
